cereal_tx_sched: RTL
====================

// Module: cereal_tx_sched
// PURPOSE
//  Buffers characters from the keyboard front end and sequences the cereal serial transmitter.
//  Sits between keyboard (req/req_data) and cereal (tx_start/tx_data/tx_busy).
//  Turns a held button level into exactly one queued character.
//  Holds tx_start for the transmitter's required time, then waits for the frame to finish.
// PARAMETERS
//  DEPTH        4     FIFO entries; power of 2, >= 2
//  HOLD_CYCLES  5702  cycles tx_start stays high per character; >= 1
//  CNT_W        13    width of hold counter; must satisfy 2**CNT_W > HOLD_CYCLES
// PORTS
//  sysclk     in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous reset, active-high
//  req        in   1  keyboard start level; may stay high for many cycles
//  req_data   in   8  ASCII character; sampled in the cycle req rises
//  tx_busy    in   1  cereal status: high while a frame is shifting out
//  tx_start   out  1  start strobe to cereal, held HOLD_CYCLES cycles
//  tx_data    out  8  character to cereal; stable for the whole HOLD and WAIT_DONE
//  fifo_full  out  1  FIFO holds DEPTH entries
//  overflow   out  1  sticky; set when a character is dropped; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; state IDLE; req edge register 0.
//  Reset mid-frame: tx_start falls at the same edge; queued characters are discarded.
//  Push:
//   - A push occurs when req=1 and req was 0 in the previous cycle (rising edge).
//   - A held req pushes once only; req going 0 then 1 again pushes again.
//   - req_data==8'h00 is never pushed, and is not counted as an overflow.
//   - If the FIFO is full at push time, the character is dropped and overflow is set.
//   - Fullness is judged before any same-cycle pop, so a push while full drops even if a pop happens in the same cycle.
//  FSM (cereal_pkg::sched_state_t):
//   IDLE: if the FIFO is not empty, pop the head into tx_data and go to HOLD. tx_start rises on the next edge.
//   HOLD: tx_start=1 for exactly HOLD_CYCLES cycles, counted by the hold counter; then tx_start=0 and go to WAIT_DONE.
//   WAIT_DONE: stay while tx_busy=1. When tx_busy=0, go to IDLE.
//   - If tx_busy never rose, WAIT_DONE exits after 1 cycle.
//   - Minimum spacing between two start pulses is HOLD_CYCLES+2 cycles.
//  Latency: push at edge N, with FSM in IDLE -> tx_start high from edge N+2.
//  FIFO order: strict FIFO. Pointers are AW=log2(DEPTH) bits plus 1 wrap bit.
//   - full when pointers differ only in the wrap bit; empty when pointers are equal.
//   - Pointers wrap modulo 2*DEPTH.
//  Simultaneous push and pop with the FIFO not full: both take effect and the count is unchanged.
//  tx_data holds its last value in IDLE; it is not cleared.
// CONFIGURATION
//  CEREAL_CRLF_EN defined:
//   - After every WAIT_DONE exit for a FIFO character, the FSM sends 8'h0D and then 8'h0A.
//   - Each uses a full HOLD/WAIT_DONE sequence, before the next FIFO pop.
//   - FSM gains states CR and LF. Pushes continue to be accepted during CR/LF.
//  CEREAL_CRLF_EN undefined: only FIFO characters are sent; the CR and LF states do not exist.
// STRUCTURE
//  cereal_pkg holds:
//   - sched_state_t enum (IDLE, HOLD, WAIT_DONE, CR, LF)
//   - ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_NUL=8'h00
//  Sub-module sync_fifo (#DEPTH, WIDTH=8) provides push/pop/full/empty/dout, with the same reset.
//  Edge detect, hold counter and FSM stay in cereal_tx_sched.
// TESTING
//  Use HOLD_CYCLES=8 for all scenarios.
//  1. req high 100 cycles, data 8'h35 -> exactly one tx_start pulse, 8 cycles wide, tx_data=8'h35; overflow=0.
//  2. 4 separate req pulses (8'h30..8'h33) within 20 cycles, tx_busy low -> start pulses in order 30,31,32,33, each 8 cycles, spacing 10 cycles.
//  3. 6 req pulses while tx_busy held 1 -> first pops; next 4 fill FIFO (fifo_full=1); 6th dropped, overflow=1; release busy -> 5 characters sent, then IDLE.
//  4. req with data 8'h00 -> no push, no tx_start, overflow stays 0.
//  5. rst asserted in the 3rd HOLD cycle with 2 entries queued -> tx_start=0 at that edge; FIFO empty; no further starts.
//  6. CEREAL_CRLF_EN, push 8'h55 -> three start pulses, tx_data 8'h55, 8'h0D, 8'h0A.

Source files
------------

// File: rtl/cereal_pkg.sv
// Shared types and constants for the cereal transmit scheduler (CR/LF states exist only with CEREAL_CRLF_EN).
// Latency: n/a (types only).
// Backpressure: n/a.
package cereal_pkg;

`ifdef CEREAL_CRLF_EN
    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        WAIT_DONE,
        CR,
        LF
    } sched_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_DONE
    } sched_state_t;
`endif

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_NUL = 8'h00;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, DEPTH entries (power of 2), wrap-bit pointers.
// Latency: push visible at dout the edge after it is written; dout is the head, read without delay.
// Backpressure: push ignored while full, pop ignored while empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sysclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cereal_tx_sched.sv
// Queues keyboard characters and paces them into the cereal transmitter; CEREAL_CRLF_EN appends CR/LF to each.
// Latency: push at edge N with FSM idle -> tx_start high from edge N+2, held HOLD_CYCLES cycles.
// Backpressure: waits on tx_busy after each hold; pushes into a full FIFO are dropped and flag overflow.
module cereal_tx_sched
    import cereal_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 5702,
    parameter int CNT_W       = 13
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] req_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       fifo_full,
    output logic       overflow
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    sched_state_t     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       tx_data_n;
    logic             req_q;
    logic             push_edge;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;

`ifdef CEREAL_CRLF_EN
    // Which character the current HOLD/WAIT_DONE belongs to: 0 FIFO char, 1 CR, 2 LF.
    logic [1:0] phase, phase_n;
`endif

    // NUL is filtered before the full check so it never counts as a drop.
    assign push_edge = req && !req_q && (req_data != ASCII_NUL);
    assign fifo_push = push_edge && !fifo_full;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .sysclk (sysclk),
        .rst    (rst),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (req_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .dout   (fifo_dout)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tx_data_n = tx_data;
        fifo_pop  = 1'b0;
`ifdef CEREAL_CRLF_EN
        phase_n   = phase;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    tx_data_n = fifo_dout;
                    state_n   = HOLD;
`ifdef CEREAL_CRLF_EN
                    phase_n   = 2'd0;
`endif
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n   = '0;
                    state_n = WAIT_DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef CEREAL_CRLF_EN
                    case (phase)
                        2'd0:    state_n = CR;
                        2'd1:    state_n = LF;
                        default: state_n = IDLE;
                    endcase
`else
                    state_n = IDLE;
`endif
                end
            end
`ifdef CEREAL_CRLF_EN
            CR: begin
                tx_data_n = ASCII_CR;
                phase_n   = 2'd1;
                state_n   = HOLD;
            end
            LF: begin
                tx_data_n = ASCII_LF;
                phase_n   = 2'd2;
                state_n   = HOLD;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // tx_start is a registered copy of the HOLD state, which gives the two-edge push-to-start latency.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            overflow <= 1'b0;
            req_q    <= 1'b0;
`ifdef CEREAL_CRLF_EN
            phase    <= 2'd0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            tx_data  <= tx_data_n;
            tx_start <= (state == HOLD);
            overflow <= overflow || (push_edge && fifo_full);
            req_q    <= req;
`ifdef CEREAL_CRLF_EN
            phase    <= phase_n;
`endif
        end
    end

endmodule
